receiver_deframer: RTL and testbench
====================================

RECEIVER_DEFRAMER -- requirements
Module: receiver_deframer

Interface
REQ-001 Parameter SYNC_WORD, 16'hB4C3, frame sync pattern, compared MSB-first.
REQ-002 Parameter TIMEOUT, 64, maximum sys_clk cycles between sym_valid pulses inside a frame.
REQ-003 sys_clk  input  1  single clock for all logic; rising-edge.
REQ-004 reset  input  1  synchronous, active-high reset.
REQ-005 is_receive  input  1  receive enable; low holds the block in HUNT.
REQ-006 sym_in  input  2  demodulated dibit, first dibit of a byte = bits[7:6].
REQ-007 sym_valid  input  1  sym_in valid this cycle; no backpressure.
REQ-008 rx_data  output  8  assembled payload byte.
REQ-009 rx_valid  output  1  one-cycle pulse, rx_data valid.
REQ-010 frame_start  output  1  one-cycle pulse on sync match.
REQ-011 frame_done  output  1  one-cycle pulse after the CRC byte completes.
REQ-012 crc_ok  output  1  valid with frame_done; held until next frame_start.
REQ-013 has_error  output  1  sticky; set on CRC mismatch or timeout; cleared on frame_start or reset.

Function
REQ-014 Frame format: SYNC_WORD (8 dibits), LEN byte, LEN payload bytes (0..255), CRC byte.
REQ-015 Bytes are assembled from 4 consecutive valid dibits, MSB-first; a 2-bit dibit counter wraps 3->0.
REQ-016 States: HUNT, LEN, PAYLOAD, CRC; only sym_valid cycles advance the datapath.
REQ-017 HUNT: a 16-bit shift register shifts in sym_in on each sym_valid; match with SYNC_WORD while is_receive=1 -> LEN, frame_start pulses next cycle.
REQ-018 LEN: after 4th dibit, store length; LEN=0 -> CRC, else -> PAYLOAD.
REQ-019 PAYLOAD: each completed byte -> rx_valid pulse with rx_data one cycle after the 4th dibit's sym_valid; after LEN bytes -> CRC.
REQ-020 CRC: CRC-8, polynomial 0x07, init 0x00, no reflection, no final XOR, computed over LEN byte and payload bytes.
REQ-021 On CRC byte completion: frame_done pulses next cycle; crc_ok=1 if received byte equals computed CRC, else crc_ok=0 and has_error=1; -> HUNT.
REQ-022 Timeout: in LEN/PAYLOAD/CRC, TIMEOUT consecutive cycles without sym_valid -> HUNT, has_error=1, no frame_done.
REQ-023 is_receive deasserted mid-frame -> HUNT next cycle, no frame_done, has_error unchanged.
REQ-024 On every entry to HUNT the sync shift register and dibit counter clear, so frame bits never form a false sync.
REQ-025 A sync pattern inside a frame is ignored (no resync until HUNT).
REQ-026 Latency from sym_valid of final CRC dibit to frame_done: exactly 1 cycle.

Reset
REQ-027 reset=1 at a rising edge: state=HUNT, rx_data=0, rx_valid=0, frame_start=0, frame_done=0, crc_ok=0, has_error=0, counters and shift register 0.
REQ-028 Reset mid-frame aborts with no output pulses on the following cycle.

Structure
REQ-029 Package receiver_pkg holds the state enum, CRC8_POLY=8'h07 and the default SYNC_WORD.
REQ-030 Sub-module crc8_update (combinational: crc_in, data_in -> crc_out) is instantiated once.

Verification
REQ-031 Sync B4C3, LEN=01, payload 5A, CRC 94 -> frame_start, rx_valid with rx_data=5A, frame_done, crc_ok=1, has_error=0.
REQ-032 Sync, LEN=00, CRC 00 -> frame_done with no rx_valid, crc_ok=1.
REQ-033 Same as REQ-031 but CRC 95 -> rx_valid 5A, frame_done, crc_ok=0, has_error=1; next good frame clears has_error at frame_start.
REQ-034 Sync, LEN=02, one payload byte then 64 idle cycles -> return to HUNT, has_error=1, no frame_done.
REQ-035 Random dibits with sym_valid gaps, then B4C3 frame -> exactly one frame_start, bytes correct irrespective of gaps.
REQ-036 reset=1 during PAYLOAD -> all outputs 0 next cycle; subsequent frame received correctly.

Source files
------------

// File: rtl/receiver_pkg.sv
`default_nettype none
// ============================================================================
// Module   : receiver_pkg
// Purpose  : Shared types and constants for the receiver deframer.
// Revision : 1.0 - initial release
// ============================================================================
package receiver_pkg;

    // Deframer states: hunting for sync, then walking the frame fields.
    typedef enum logic [1:0] {
        ST_HUNT    = 2'd0,
        ST_LEN     = 2'd1,
        ST_PAYLOAD = 2'd2,
        ST_CRC     = 2'd3
    } rx_state_e;

    // CRC-8 generator x^8 + x^2 + x + 1, non-reflected.
    localparam logic [7:0]  CRC8_POLY         = 8'h07;

    // Frame sync pattern, compared MSB-first.
    localparam logic [15:0] DEFAULT_SYNC_WORD = 16'hB4C3;

endpackage
`default_nettype wire

// File: rtl/receiver_deframer_crc8.sv
`default_nettype none
// ============================================================================
// Module   : crc8_update
// Purpose  : Combinational single-byte CRC-8 step (MSB-first, no reflection).
// Revision : 1.0 - initial release
// ============================================================================
module crc8_update
    import receiver_pkg::*;
(
    input  logic [7:0] crc_in,
    input  logic [7:0] data_in,
    output logic [7:0] crc_out
);

    logic [7:0] crc_work;

    // Fold the byte into the running CRC, then clock the register 8 times.
    always_comb begin
        crc_work = crc_in ^ data_in;
        for (int i = 0; i < 8; i++) begin
            if (crc_work[7]) begin
                crc_work = {crc_work[6:0], 1'b0} ^ CRC8_POLY;
            end else begin
                crc_work = {crc_work[6:0], 1'b0};
            end
        end
        crc_out = crc_work;
    end

endmodule
`default_nettype wire

// File: rtl/receiver_deframer.sv
`default_nettype none
// ============================================================================
// Module   : receiver_deframer
// Purpose  : Hunts for a 16-bit sync word in a dibit stream, then extracts
//            LEN, LEN payload bytes and a CRC-8 byte, flagging errors.
// Revision : 1.0 - initial release
// ============================================================================
module receiver_deframer
    import receiver_pkg::*;
#(
    parameter logic [15:0] SYNC_WORD = DEFAULT_SYNC_WORD,
    parameter int unsigned TIMEOUT   = 64
) (
    input  logic       sys_clk,
    input  logic       reset,
    input  logic       is_receive,
    input  logic [1:0] sym_in,
    input  logic       sym_valid,
    output logic [7:0] rx_data,
    output logic       rx_valid,
    output logic       frame_start,
    output logic       frame_done,
    output logic       crc_ok,
    output logic       has_error
);

    // Idle counter runs 0..TIMEOUT-1; reaching the last value while idle aborts.
    localparam int             TO_W    = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT - 1);

    rx_state_e        state_q,       state_d;
    // Only the 7 most recent dibits are stored; the live dibit completes the
    // 16-bit comparison window, so a match is seen on the 8th sync dibit.
    logic [13:0]      sync_shift_q,  sync_shift_d;
    logic [1:0]       dibit_cnt_q,   dibit_cnt_d;
    logic [5:0]       acc_q,         acc_d;
    logic [7:0]       len_q,         len_d;
    logic [7:0]       byte_cnt_q,    byte_cnt_d;
    logic [7:0]       crc_q,         crc_d;
    logic [TO_W-1:0]  idle_cnt_q,    idle_cnt_d;
    logic [7:0]       rx_data_q,     rx_data_d;
    logic             rx_valid_q,    rx_valid_d;
    logic             frame_start_q, frame_start_d;
    logic             frame_done_q,  frame_done_d;
    logic             crc_ok_q,      crc_ok_d;
    logic             has_error_q,   has_error_d;

    logic [15:0]      sync_window;
    logic [7:0]       byte_now;
    logic [7:0]       crc_next;

    assign sync_window = {sync_shift_q, sym_in};
    assign byte_now    = {acc_q, sym_in};

    crc8_update u_crc8 (
        .crc_in  (crc_q),
        .data_in (byte_now),
        .crc_out (crc_next)
    );

    // Next-state and output decode; only sym_valid cycles move the datapath.
    always_comb begin
        state_d       = state_q;
        sync_shift_d  = sync_shift_q;
        dibit_cnt_d   = dibit_cnt_q;
        acc_d         = acc_q;
        len_d         = len_q;
        byte_cnt_d    = byte_cnt_q;
        crc_d         = crc_q;
        idle_cnt_d    = idle_cnt_q;
        rx_data_d     = rx_data_q;
        rx_valid_d    = 1'b0;
        frame_start_d = 1'b0;
        frame_done_d  = 1'b0;
        crc_ok_d      = crc_ok_q;
        has_error_d   = has_error_q;

        if (state_q == ST_HUNT) begin
            if (sym_valid) begin
                sync_shift_d = sync_window[13:0];
                if (is_receive && (sync_window == SYNC_WORD)) begin
                    state_d       = ST_LEN;
                    frame_start_d = 1'b1;
                    has_error_d   = 1'b0;
                    crc_ok_d      = 1'b0;
                    sync_shift_d  = '0;
                    dibit_cnt_d   = '0;
                    acc_d         = '0;
                    crc_d         = '0;
                    byte_cnt_d    = '0;
                    idle_cnt_d    = '0;
                end
            end
        end else begin
            if (!is_receive) begin
                state_d = ST_HUNT;
            end else if (sym_valid) begin
                idle_cnt_d  = '0;
                acc_d       = byte_now[5:0];
                dibit_cnt_d = dibit_cnt_q + 2'd1;
                if (dibit_cnt_q == 2'd3) begin
                    case (state_q)
                        ST_LEN: begin
                            len_d      = byte_now;
                            crc_d      = crc_next;
                            byte_cnt_d = '0;
                            state_d    = (byte_now == 8'd0) ? ST_CRC : ST_PAYLOAD;
                        end
                        ST_PAYLOAD: begin
                            rx_data_d  = byte_now;
                            rx_valid_d = 1'b1;
                            crc_d      = crc_next;
                            byte_cnt_d = byte_cnt_q + 8'd1;
                            if ((byte_cnt_q + 8'd1) == len_q) begin
                                state_d = ST_CRC;
                            end
                        end
                        default: begin
                            frame_done_d = 1'b1;
                            crc_ok_d     = (byte_now == crc_q);
                            if (byte_now != crc_q) begin
                                has_error_d = 1'b1;
                            end
                            state_d = ST_HUNT;
                        end
                    endcase
                end
            end else if (idle_cnt_q == TO_LAST) begin
                has_error_d = 1'b1;
                state_d     = ST_HUNT;
            end else begin
                idle_cnt_d = idle_cnt_q + 1'b1;
            end

            // Every return to HUNT starts the sync search from a clean slate.
            if (state_d == ST_HUNT) begin
                sync_shift_d = '0;
                dibit_cnt_d  = '0;
                acc_d        = '0;
                idle_cnt_d   = '0;
            end
        end
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge sys_clk) begin
        if (reset) begin
            state_q       <= ST_HUNT;
            sync_shift_q  <= '0;
            dibit_cnt_q   <= '0;
            acc_q         <= '0;
            len_q         <= '0;
            byte_cnt_q    <= '0;
            crc_q         <= '0;
            idle_cnt_q    <= '0;
            rx_data_q     <= '0;
            rx_valid_q    <= 1'b0;
            frame_start_q <= 1'b0;
            frame_done_q  <= 1'b0;
            crc_ok_q      <= 1'b0;
            has_error_q   <= 1'b0;
        end else begin
            state_q       <= state_d;
            sync_shift_q  <= sync_shift_d;
            dibit_cnt_q   <= dibit_cnt_d;
            acc_q         <= acc_d;
            len_q         <= len_d;
            byte_cnt_q    <= byte_cnt_d;
            crc_q         <= crc_d;
            idle_cnt_q    <= idle_cnt_d;
            rx_data_q     <= rx_data_d;
            rx_valid_q    <= rx_valid_d;
            frame_start_q <= frame_start_d;
            frame_done_q  <= frame_done_d;
            crc_ok_q      <= crc_ok_d;
            has_error_q   <= has_error_d;
        end
    end

    assign rx_data     = rx_data_q;
    assign rx_valid    = rx_valid_q;
    assign frame_start = frame_start_q;
    assign frame_done  = frame_done_q;
    assign crc_ok      = crc_ok_q;
    assign has_error   = has_error_q;

endmodule
`default_nettype wire

// File: tb/tb_receiver_deframer.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module   : tb_receiver_deframer
// Purpose  : Randomised self-checking bench for receiver_deframer.
// Revision : 1.0 - initial release
// ============================================================================
module tb_receiver_deframer;

    localparam logic [15:0] SYNC = 16'hB4C3;
    localparam int          TMO  = 64;

    logic       sys_clk    = 1'b0;
    logic       reset      = 1'b1;
    logic       is_receive = 1'b0;
    logic [1:0] sym_in     = 2'd0;
    logic       sym_valid  = 1'b0;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic       frame_start;
    logic       frame_done;
    logic       crc_ok;
    logic       has_error;

    receiver_deframer #(
        .SYNC_WORD (SYNC),
        .TIMEOUT   (TMO)
    ) dut (
        .sys_clk     (sys_clk),
        .reset       (reset),
        .is_receive  (is_receive),
        .sym_in      (sym_in),
        .sym_valid   (sym_valid),
        .rx_data     (rx_data),
        .rx_valid    (rx_valid),
        .frame_start (frame_start),
        .frame_done  (frame_done),
        .crc_ok      (crc_ok),
        .has_error   (has_error)
    );

    always #5 sys_clk = ~sys_clk;

    int         n_checks = 0;
    int         n_errors = 0;
    int         fs_cnt   = 0;
    int         fd_cnt   = 0;
    logic       err_at_start = 1'b0;
    logic [7:0] got_q[$];

    // Observe pulses mid-cycle, away from the active edge.
    always @(negedge sys_clk) begin
        if (frame_start) begin
            fs_cnt++;
            err_at_start = has_error;
        end
        if (frame_done) fd_cnt++;
        if (rx_valid) got_q.push_back(rx_data);
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Reference CRC-8: bit-serial long division of the message by 0x107.
    function automatic logic [7:0] crc8_ref(input logic [7:0] msg[$]);
        logic [7:0] r;
        logic       fb;
        r = 8'h00;
        foreach (msg[i]) begin
            for (int b = 7; b >= 0; b--) begin
                fb = r[7] ^ msg[i][b];
                r  = {r[6:0], 1'b0};
                if (fb) r = r ^ 8'h07;
            end
        end
        return r;
    endfunction

    // Index of the last dibit of the first 8-dibit run equal to SYNC, or -1.
    function automatic int first_sync(input logic [1:0] s[$]);
        logic [15:0] sw;
        bit          hit;
        sw = SYNC;
        for (int i = 7; i < s.size(); i++) begin
            hit = 1'b1;
            for (int k = 0; k < 8; k++) begin
                if (s[i - 7 + k] != sw[15 - 2*k -: 2]) hit = 1'b0;
            end
            if (hit) return i;
        end
        return -1;
    endfunction

    task automatic drive(input logic v, input logic [1:0] d);
        @(posedge sys_clk);
        #1;
        sym_valid = v;
        sym_in    = d;
    endtask

    task automatic send_dibit(input logic [1:0] d, input int max_gap);
        int gap;
        gap = $urandom_range(max_gap, 0);
        repeat (gap) drive(1'b0, 2'($urandom_range(3, 0)));
        drive(1'b1, d);
    endtask

    task automatic send_byte(input logic [7:0] b, input int max_gap);
        for (int k = 3; k >= 0; k--) send_dibit(b[2*k+1 -: 2], max_gap);
    endtask

    task automatic send_sync(input int max_gap);
        logic [15:0] sw;
        sw = SYNC;
        for (int k = 7; k >= 0; k--) send_dibit(sw[2*k+1 -: 2], max_gap);
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, ".rx_data"},     {24'd0, rx_data}, 32'd0);
        check({tag, ".rx_valid"},    {31'd0, rx_valid}, 32'd0);
        check({tag, ".frame_start"}, {31'd0, frame_start}, 32'd0);
        check({tag, ".frame_done"},  {31'd0, frame_done}, 32'd0);
        check({tag, ".crc_ok"},      {31'd0, crc_ok}, 32'd0);
        check({tag, ".has_error"},   {31'd0, has_error}, 32'd0);
    endtask

    // Send one complete frame and check every observable consequence.
    task automatic run_frame(input string tag, input logic [7:0] payload[$],
                             input logic [7:0] flip, input int max_gap, input int stall);
        logic [7:0] body[$];
        logic [7:0] c;
        int         fs0;
        int         fd0;
        int         n;
        body.push_back(8'(payload.size()));
        foreach (payload[i]) body.push_back(payload[i]);
        c = crc8_ref(body) ^ flip;
        body.push_back(c);
        got_q.delete();
        fs0 = fs_cnt;
        fd0 = fd_cnt;
        send_sync(max_gap);
        foreach (body[i]) begin
            send_byte(body[i], max_gap);
            if (i == 0) repeat (stall) drive(1'b0, 2'd0);
        end
        drive(1'b0, 2'd0);
        check({tag, ".done_latency"}, {31'd0, frame_done}, 32'd1);
        check({tag, ".crc_ok"},       {31'd0, crc_ok}, {31'd0, (flip == 8'd0)});
        check({tag, ".has_error"},    {31'd0, has_error}, {31'd0, (flip != 8'd0)});
        repeat (2) drive(1'b0, 2'd0);
        check({tag, ".starts"},       fs_cnt - fs0, 32'd1);
        check({tag, ".dones"},        fd_cnt - fd0, 32'd1);
        check({tag, ".err_cleared"},  {31'd0, err_at_start}, 32'd0);
        check({tag, ".nbytes"},       got_q.size(), payload.size());
        n = (got_q.size() < payload.size()) ? got_q.size() : payload.size();
        for (int i = 0; i < n; i++) begin
            check($sformatf("%s.byte%0d", tag, i), {24'd0, got_q[i]}, {24'd0, payload[i]});
        end
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [7:0] pl[$];
        logic [1:0] noise[$];
        logic [1:0] stream[$];
        logic [15:0] sw;
        int          fd0;
        int          tries;
        logic        err0;

        // Reset state.
        repeat (3) drive(1'b0, 2'd0);
        check_all_zero("reset");
        @(posedge sys_clk);
        #1;
        reset      = 1'b0;
        is_receive = 1'b1;
        repeat (2) drive(1'b0, 2'd0);

        // Basic, empty and corrupted frames; recovery clears has_error.
        pl = '{8'h5A};
        run_frame("basic", pl, 8'h00, 0, 0);
        pl.delete();
        run_frame("len0", pl, 8'h00, 0, 0);
        pl = '{8'h5A};
        run_frame("badcrc", pl, 8'h01, 0, 0);
        run_frame("recover", pl, 8'h00, 2, 0);

        // Longest tolerated silence inside a frame.
        pl = '{8'h3C, 8'hE1};
        run_frame("stall63", pl, 8'h00, 0, TMO - 1);

        // Timeout after one payload byte of a two-byte frame.
        fd0 = fd_cnt;
        send_sync(0);
        send_byte(8'h02, 0);
        send_byte(8'hA7, 0);
        repeat (TMO) drive(1'b0, 2'd0);
        check("tmo.before", {31'd0, has_error}, 32'd0);
        drive(1'b0, 2'd0);
        check("tmo.error", {31'd0, has_error}, 32'd1);
        repeat (3) drive(1'b0, 2'd0);
        check("tmo.no_done", fd_cnt - fd0, 32'd0);
        pl = '{8'h11, 8'h22, 8'h33};
        run_frame("after_tmo", pl, 8'h00, 1, 0);

        // Receive disabled mid-frame.
        fd0 = fd_cnt;
        send_sync(0);
        send_byte(8'h02, 0);
        send_byte(8'h11, 0);
        err0 = has_error;
        @(posedge sys_clk);
        #1;
        is_receive = 1'b0;
        sym_valid  = 1'b0;
        drive(1'b0, 2'd0);
        is_receive = 1'b1;
        repeat (3) drive(1'b0, 2'd0);
        check("abort.no_done", fd_cnt - fd0, 32'd0);
        check("abort.err_kept", {31'd0, has_error}, {31'd0, err0});
        pl = '{8'h44};
        run_frame("after_abort", pl, 8'h00, 0, 0);

        // Sync pattern carried as payload must not resync.
        pl = '{8'hB4, 8'hC3, 8'hB4, 8'hC3, 8'hB4, 8'hC3};
        run_frame("insync", pl, 8'h00, 1, 0);

        // Random noise with gaps, chosen so the first sync is the real one.
        sw = SYNC;
        tries = 0;
        do begin
            noise.delete();
            stream.delete();
            repeat (40) noise.push_back(2'($urandom_range(3, 0)));
            repeat (7) stream.push_back(2'd0);
            foreach (noise[i]) stream.push_back(noise[i]);
            for (int k = 7; k >= 0; k--) stream.push_back(sw[2*k+1 -: 2]);
            tries++;
        end while (first_sync(stream) != stream.size() - 1 && tries < 200);
        foreach (noise[i]) send_dibit(noise[i], 3);
        pl.delete();
        repeat (5) pl.push_back(8'($urandom_range(255, 0)));
        run_frame("noise", pl, 8'h00, 3, 0);

        // Reset landing on a completing payload byte.
        send_sync(0);
        send_byte(8'h03, 0);
        send_byte(8'h12, 0);
        send_dibit(2'b01, 0);
        send_dibit(2'b10, 0);
        send_dibit(2'b11, 0);
        @(posedge sys_clk);
        #1;
        reset     = 1'b1;
        sym_valid = 1'b1;
        sym_in    = 2'b00;
        @(posedge sys_clk);
        #1;
        sym_valid = 1'b0;
        check_all_zero("mid_reset");
        reset = 1'b0;
        repeat (2) drive(1'b0, 2'd0);
        pl = '{8'h9E, 8'h07};
        run_frame("after_reset", pl, 8'h00, 1, 0);

        // Randomised frames, some with corrupted CRC.
        for (int f = 0; f < 8; f++) begin
            logic [7:0] flip;
            pl.delete();
            repeat ($urandom_range(12, 0)) pl.push_back(8'($urandom_range(255, 0)));
            flip = ($urandom_range(2, 0) == 0) ? 8'($urandom_range(255, 1)) : 8'h00;
            run_frame($sformatf("rand%0d", f), pl, flip, 3, 0);
        end

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
